// File: rtl/oflow_features_extractor.sv
// First optical-flow stage: unpacks a bbox descriptor into registered CM, corner, size, color and history features.
// Optional macro FE_VALID_OUT_EN adds a registered fe_valid strobe output.
module oflow_features_extractor #(
    parameter int CM_LEN        = 11,
    parameter int WIDTH_LEN     = 10,
    parameter int HEIGHT_LEN    = 10,
    parameter int COLOR_LEN     = 24,
    parameter int D_HISTORY_LEN = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_N,
    input  logic [2*CM_LEN+WIDTH_LEN+HEIGHT_LEN+2*COLOR_LEN+D_HISTORY_LEN-1:0] bbox,
    input  logic                                  fe_enable,
    output logic [2*CM_LEN-1:0]                   cm_concate,
    output logic [4*CM_LEN-1:0]                   position_concate,
    output logic [WIDTH_LEN-1:0]                  width,
    output logic [HEIGHT_LEN-1:0]                 height,
    output logic [COLOR_LEN-1:0]                  color1,
    output logic [COLOR_LEN-1:0]                  color2,
`ifdef FE_VALID_OUT_EN
    output logic                                  fe_valid,
`endif
    output logic [D_HISTORY_LEN-1:0]              d_history
);

    localparam int BBOX_VECTOR_SIZE     = 2*CM_LEN + WIDTH_LEN + HEIGHT_LEN + 2*COLOR_LEN + D_HISTORY_LEN;
    localparam int CM_CONCATE_LEN       = 2*CM_LEN;
    localparam int POSITION_CONCATE_LEN = 4*CM_LEN;

    // Sums are formed one bit wider than a coordinate so overflow is visible and clamps to full scale.
    function automatic logic [CM_LEN-1:0] sat_add(input logic [CM_LEN-1:0] a,
                                                  input logic [CM_LEN:0]   b);
        logic [CM_LEN:0] sum;
        sum = {1'b0, a} + b;
        return sum[CM_LEN] ? {CM_LEN{1'b1}} : sum[CM_LEN-1:0];
    endfunction

    logic [CM_LEN-1:0]        x_in, y_in;
    logic [WIDTH_LEN-1:0]     w_in;
    logic [HEIGHT_LEN-1:0]    h_in;
    logic [COLOR_LEN-1:0]     c1_in, c2_in;
    logic [D_HISTORY_LEN-1:0] dh_in;

    logic [CM_CONCATE_LEN-1:0]       cm_d, cm_q;
    logic [POSITION_CONCATE_LEN-1:0] pos_d, pos_q;
    logic [WIDTH_LEN-1:0]            width_d, width_q;
    logic [HEIGHT_LEN-1:0]           height_d, height_q;
    logic [COLOR_LEN-1:0]            color1_d, color1_q;
    logic [COLOR_LEN-1:0]            color2_d, color2_q;
    logic [D_HISTORY_LEN-1:0]        d_history_d, d_history_q;
    logic                            valid_d, valid_q;

    always_comb begin
        {x_in, y_in, w_in, h_in, c1_in, c2_in, dh_in} = bbox;
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        cm_d        = cm_q;
        pos_d       = pos_q;
        width_d     = width_q;
        height_d    = height_q;
        color1_d    = color1_q;
        color2_d    = color2_q;
        d_history_d = d_history_q;
        valid_d     = fe_enable;
        if (fe_enable) begin
            cm_d        = {sat_add(x_in, (CM_LEN+1)'(w_in >> 1)),
                           sat_add(y_in, (CM_LEN+1)'(h_in >> 1))};
            pos_d       = {x_in, y_in,
                           sat_add(x_in, (CM_LEN+1)'(w_in)),
                           sat_add(y_in, (CM_LEN+1)'(h_in))};
            width_d     = w_in;
            height_d    = h_in;
            color1_d    = c1_in;
            color2_d    = c2_in;
            d_history_d = dh_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            cm_q        <= '0;
            pos_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            color1_q    <= '0;
            color2_q    <= '0;
            d_history_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            cm_q        <= cm_d;
            pos_q       <= pos_d;
            width_q     <= width_d;
            height_q    <= height_d;
            color1_q    <= color1_d;
            color2_q    <= color2_d;
            d_history_q <= d_history_d;
            valid_q     <= valid_d;
        end
    end

    assign cm_concate       = cm_q;
    assign position_concate = pos_q;
    assign width            = width_q;
    assign height           = height_q;
    assign color1           = color1_q;
    assign color2           = color2_q;
    assign d_history        = d_history_q;

`ifdef FE_VALID_OUT_EN
    assign fe_valid = valid_q;
`else
    logic unused_valid;
    assign unused_valid = valid_q;
`endif

endmodule

// File: tb/tb_oflow_features_extractor.sv
// Directed scoreboard bench for oflow_features_extractor; expected features come from an integer reference model.
module tb_oflow_features_extractor;

    localparam int BBW = 93;

    typedef struct packed {
        logic [21:0] cm;
        logic [43:0] pos;
        logic [9:0]  w;
        logic [9:0]  h;
        logic [23:0] c1;
        logic [23:0] c2;
        logic [2:0]  dh;
        logic        vld;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_N = 1'b0;
    logic [BBW-1:0] bbox = '0;
    logic           fe_enable = 1'b0;
    logic [21:0]    cm_concate;
    logic [43:0]    position_concate;
    logic [9:0]     width, height;
    logic [23:0]    color1, color2;
    logic [2:0]     d_history;
`ifdef FE_VALID_OUT_EN
    logic           fe_valid;
`endif

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t held;

    oflow_features_extractor dut (
        .clk              (clk),
        .reset_N          (reset_N),
        .bbox             (bbox),
        .fe_enable        (fe_enable),
        .cm_concate       (cm_concate),
        .position_concate (position_concate),
        .width            (width),
        .height           (height),
        .color1           (color1),
        .color2           (color2),
`ifdef FE_VALID_OUT_EN
        .fe_valid         (fe_valid),
`endif
        .d_history        (d_history)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 2047) ? 2047 : v;
    endfunction

    function automatic exp_t model(input int x, input int y, input int w, input int h,
                                   input int c1, input int c2, input int dh);
        exp_t e;
        e.cm  = {11'(sat(x + w / 2)), 11'(sat(y + h / 2))};
        e.pos = {11'(x), 11'(y), 11'(sat(x + w)), 11'(sat(y + h))};
        e.w   = 10'(w);
        e.h   = 10'(h);
        e.c1  = 24'(c1);
        e.c2  = 24'(c2);
        e.dh  = 3'(dh);
        e.vld = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".cm"},       64'(cm_concate),       64'(e.cm));
        chk({tag, ".pos"},      64'(position_concate), 64'(e.pos));
        chk({tag, ".width"},    64'(width),            64'(e.w));
        chk({tag, ".height"},   64'(height),           64'(e.h));
        chk({tag, ".color1"},   64'(color1),           64'(e.c1));
        chk({tag, ".color2"},   64'(color2),           64'(e.c2));
        chk({tag, ".dhist"},    64'(d_history),        64'(e.dh));
`ifdef FE_VALID_OUT_EN
        chk({tag, ".fe_valid"}, 64'(fe_valid),         64'(e.vld));
`endif
    endtask

    // Drive one bbox before an edge, then compare one sample after that edge.
    task automatic cycle(input string tag, input bit en, input int x, input int y, input int w,
                         input int h, input int c1, input int c2, input int dh);
        exp_t e;
        @(negedge clk);
        bbox      = {11'(x), 11'(y), 10'(w), 10'(h), 24'(c1), 24'(c2), 3'(dh)};
        fe_enable = en;
        if (en) sb.push_back(model(x, y, w, h, c1, c2, dh));
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e = held;
            e.vld = 1'b0;
        end
        check_all(tag, e);
        held = e;
    endtask

    initial begin
        held = '0;

        // Reset held with enable and random input: outputs stay zero.
        #1;
        check_all("rst0", held);
        @(negedge clk);
        fe_enable = 1'b1;
        bbox = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold", held);
        end
        @(negedge clk);
        fe_enable = 1'b0;
        reset_N = 1'b1;

        cycle("basic", 1'b1, 50, 10, 10, 100, 50, 60, 6);

        for (int i = 0; i < 10; i++) cycle("hold", 1'b0, 30, 70, 10, 100, 50, 60, 6);
        cycle("pulse", 1'b1, 30, 70, 10, 100, 50, 60, 6);
        cycle("after_pulse", 1'b0, 30, 70, 10, 100, 50, 60, 6);

        cycle("odd", 1'b1, 0, 0, 11, 7, 24'hABCDEF, 24'h123456, 5);
        cycle("b2b_a", 1'b1, 100, 200, 1023, 1023, 1, 2, 3);
        cycle("b2b_b", 1'b1, 1024, 1023, 1023, 1023, 24'hFFFFFF, 0, 7);
        cycle("sat", 1'b1, 2040, 2000, 20, 100, 7, 8, 1);
        cycle("exact_max", 1'b1, 2037, 2046, 10, 1, 9, 9, 2);
        cycle("sat2", 1'b1, 2040, 2000, 20, 100, 7, 8, 1);

        // Asynchronous reset between edges clears outputs before the next edge.
        @(posedge clk);
        #3;
        reset_N = 1'b0;
        #1;
        held = '0;
        check_all("async_rst", held);
        @(negedge clk);
        fe_enable = 1'b0;
        reset_N = 1'b1;

        cycle("post_rst_idle", 1'b0, 5, 5, 5, 5, 5, 5, 5);
        cycle("post_rst", 1'b1, 5, 6, 7, 9, 11, 12, 4);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/oflow_features_extractor.md
Name: oflow_features_extractor

Overview:
- First pipeline stage of the optical-flow tracker.
- Takes one packed bounding-box descriptor per cycle and unpacks it into the feature fields used by the downstream scoring/matching logic.
- Derives the center of mass (CM) and the corner positions from the top-left corner plus width/height; color and history fields pass through unchanged.
- All outputs are registered.

Parameters:
- CM_LEN, 11, width of one coordinate (x or y) and of each CM/corner coordinate.
- WIDTH_LEN, 10, bbox width field width.
- HEIGHT_LEN, 10, bbox height field width.
- COLOR_LEN, 24, width of each color feature.
- D_HISTORY_LEN, 3, detection-history field width.
- Derived, not overridable:
  - BBOX_VECTOR_SIZE = 2*CM_LEN + WIDTH_LEN + HEIGHT_LEN + 2*COLOR_LEN + D_HISTORY_LEN
  - CM_CONCATE_LEN = 2*CM_LEN
  - POSITION_CONCATE_LEN = 4*CM_LEN

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_N  in  1  asynchronous, active-low reset.
- bbox  in  BBOX_VECTOR_SIZE  packed {x, y, width, height, color1, color2, d_history}, x in the MSBs; x,y = top-left corner.
- fe_enable  in  1  capture/compute strobe.
- cm_concate  out  CM_CONCATE_LEN  {cm_x, cm_y}.
- position_concate  out  POSITION_CONCATE_LEN  {x_tl, y_tl, x_br, y_br}.
- width  out  WIDTH_LEN  registered bbox width.
- height  out  HEIGHT_LEN  registered bbox height.
- color1  out  COLOR_LEN  registered color1.
- color2  out  COLOR_LEN  registered color2.
- d_history  out  D_HISTORY_LEN  registered history.

Behaviour:
- Reset (reset_N low, asynchronous): every output register goes to 0 immediately and holds 0 while reset is asserted. Reset takes priority over fe_enable. Reset asserted mid-operation discards the captured data.
- Rising edge with fe_enable=1: all outputs update from the current bbox. Latency is 1 cycle; new data is accepted every cycle with no stall.
- Rising edge with fe_enable=0: all outputs hold their previous values.
- Field slicing is MSB to LSB in the order listed on the bbox port.
- cm_x = x + floor(width/2); cm_y = y + floor(height/2). Halving is a right shift by 1, so an odd width rounds down.
- x_tl = x; y_tl = y; x_br = x + width; y_br = y + height.
- Sums are computed at CM_LEN+1 bits. If a result exceeds 2^CM_LEN-1 it saturates to 2^CM_LEN-1. No wrap-around.
- width, height, color1, color2 and d_history pass through unchanged.
- The design is purely combinational arithmetic into a single register stage; no FSM.

Optional Feature:
- Macro: FE_VALID_OUT_EN.
- Defined: adds port fe_valid (out, 1 bit), a register of fe_enable. It goes high the cycle the outputs update, is low otherwise, and resets to 0.
- Undefined: no fe_valid port; all other behaviour is identical.

Test Plan:
- Reset, then hold reset_N low for 2 cycles with fe_enable=1 and random bbox -> all outputs stay 0.
- bbox x=50,y=10,w=10,h=100,c1=50,c2=60,dh=6, fe_enable=1 for one edge -> next cycle cm={55,60}, position={50,10,60,110}, width=10, height=100, color1=50, color2=60, d_history=6.
- After the above, drop fe_enable and apply x=30,y=70 -> outputs unchanged for 10 cycles. Then pulse fe_enable -> cm={35,120}, position={30,70,40,170}.
- Odd sizes x=0,y=0,w=11,h=7 -> cm={5,3}, position={0,0,11,7}.
- Saturation x=2040,y=2000,w=20,h=100 -> cm={2047,2047}, position={2040,2000,2047,2047}.
- Assert reset_N low between edges while outputs are non-zero -> outputs go to 0 before the next edge. With FE_VALID_OUT_EN defined, fe_valid pulses exactly one cycle per single-cycle fe_enable.
